// File: rtl/num_entry_if.sv
// num_entry_if: bundles the button/switch inputs, the parallel-load port and
// the registered digit outputs of num_entry.
// Ports: btn/sw (raw buttons/direction switches), load/load_val (parallel
// load), num (packed hex digits), step (one-cycle per-digit step strobe).
interface num_entry_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   btn;
  logic [DIGITS-1:0]   sw;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] num;
  logic [DIGITS-1:0]   step;

  // master drives the controls and observes the value; slave is the block
  modport master (
    output btn, sw, load, load_val,
    input  num, step
  );

  modport slave (
    input  btn, sw, load, load_val,
    output num, step
  );
endinterface

// File: rtl/num_entry.sv
// num_entry: per-digit hex entry. Each raw button is synchronised and
// debounced; a debounced press steps its 4-bit digit up or down (per the
// synced direction switch), wrapping or saturating per SAT_MODE. A load
// strobe overwrites all digits and suppresses that cycle's steps.
// Ports: clk, rst (sync, active high), bus (num_entry_if.slave: btn, sw,
// load, load_val in; num, step out; both outputs registered).
// Optional: define NUM_ENTRY_AUTOREPEAT_EN for hold-to-repeat stepping after
// REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
module num_entry #(
  parameter int                  DIGITS        = 4,
  parameter logic [4*DIGITS-1:0] INIT          = 'hABCD,
  parameter int                  DEB_CYCLES    = 4,
  parameter int                  SAT_MODE      = 0,
  parameter int                  REPEAT_DELAY  = 50,
  parameter int                  REPEAT_PERIOD = 10
) (
  input logic        clk,
  input logic        rst,
  num_entry_if.slave bus
);

  // Parameter legality, caught at elaboration.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("num_entry: DIGITS must be in 1..8");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("num_entry: DEB_CYCLES must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("num_entry: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  // Debounce counter only needs to reach DEB_CYCLES-1: the DEB_CYCLES-th
  // mismatching cycle commits the new level instead of incrementing.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [DIGITS-1:0]   btn_s1, btn_s2;
  logic [DIGITS-1:0]   sw_s1, sw_s2;
  logic [DIGITS-1:0]   deb, deb_nxt;
  logic [CW-1:0]       cnt     [DIGITS];
  logic [CW-1:0]       cnt_nxt [DIGITS];
  logic [DIGITS-1:0]   rise;
  logic [DIGITS-1:0]   fire;
  logic [4*DIGITS-1:0] num_r, num_nxt;
  logic [DIGITS-1:0]   step_r;

`ifdef NUM_ENTRY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  // rep_cnt counts held cycles since the last step of this channel;
  // rep_late marks that the first (longer) delay has already elapsed.
  logic [RW-1:0]     rep_cnt     [DIGITS];
  logic [RW-1:0]     rep_cnt_nxt [DIGITS];
  logic [DIGITS-1:0] rep_late, rep_late_nxt;
  logic [DIGITS-1:0] rep_fire;
`endif

  // One step of a single digit; sat selects clamp instead of mod-16 wrap.
  function automatic logic [3:0] step_digit(input logic [3:0] d, input logic dn);
    logic [3:0] r;
    if (dn) begin
      r = (SAT_MODE != 0 && d == 4'h0) ? d : d - 4'd1;
    end else begin
      r = (SAT_MODE != 0 && d == 4'hF) ? d : d + 4'd1;
    end
    return r;
  endfunction

  always_comb begin
    deb_nxt = deb;
    num_nxt = num_r;
    for (int i = 0; i < DIGITS; i++) begin
      cnt_nxt[i] = '0;
      if (btn_s2[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_nxt[i] = btn_s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end

    // Only presses step; releases are silent.
    rise = deb_nxt & ~deb;
    fire = rise;

`ifdef NUM_ENTRY_AUTOREPEAT_EN
    rep_fire = '0;
    for (int i = 0; i < DIGITS; i++) begin
      rep_cnt_nxt[i]  = '0;
      rep_late_nxt[i] = 1'b0;
      // Repeat only while the button stays held through this edge, so a
      // release completing on a repeat edge does not add a stray step.
      if (deb[i] && deb_nxt[i]) begin
        if (rep_cnt[i] == (rep_late[i] ? PER_LAST : DLY_LAST)) begin
          rep_fire[i]     = 1'b1;
          rep_late_nxt[i] = 1'b1;
        end else begin
          rep_cnt_nxt[i]  = rep_cnt[i] + 1'b1;
          rep_late_nxt[i] = rep_late[i];
        end
      end
    end
    fire = rise | rep_fire;
`endif

    for (int i = 0; i < DIGITS; i++) begin
      if (fire[i]) begin
        num_nxt[4*i +: 4] = step_digit(num_r[4*i +: 4], sw_s2[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
      deb    <= '0;
      num_r  <= INIT;
      step_r <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        cnt[i] <= '0;
      end
`ifdef NUM_ENTRY_AUTOREPEAT_EN
      rep_late <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        rep_cnt[i] <= '0;
      end
`endif
    end else begin
      btn_s1 <= bus.btn;
      btn_s2 <= btn_s1;
      sw_s1  <= bus.sw;
      sw_s2  <= sw_s1;
      deb    <= deb_nxt;
      for (int i = 0; i < DIGITS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
`ifdef NUM_ENTRY_AUTOREPEAT_EN
      // Repeat timing keeps running through a load; only the step is lost.
      rep_late <= rep_late_nxt;
      for (int i = 0; i < DIGITS; i++) begin
        rep_cnt[i] <= rep_cnt_nxt[i];
      end
`endif
      if (bus.load) begin
        num_r  <= bus.load_val;
        step_r <= '0;
      end else begin
        num_r  <= num_nxt;
        step_r <= fire;
      end
    end
  end

  assign bus.num  = num_r;
  assign bus.step = step_r;

endmodule

// File: tb/tb_num_entry.sv
// tb_num_entry: drives a wrapping and a saturating num_entry with shared
// stimulus (directed cases followed by random button/switch/load/reset
// activity) and compares both against a cycle-level behavioural model.
module tb_num_entry;
  localparam int DIGITS = 4;
  localparam int DEB    = 4;
  localparam int RDLY   = 50;
  localparam int RPER   = 10;
  localparam logic [15:0] INIT = 16'hABCD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DIGITS-1:0] btn_r = '0;
  logic [DIGITS-1:0] sw_r = '0;
  logic load_r = 1'b0;
  logic [15:0] load_val_r = '0;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  num_entry_if #(.DIGITS(DIGITS)) ifa ();
  num_entry_if #(.DIGITS(DIGITS)) ifb ();

  assign ifa.btn = btn_r;
  assign ifa.sw = sw_r;
  assign ifa.load = load_r;
  assign ifa.load_val = load_val_r;
  assign ifb.btn = btn_r;
  assign ifb.sw = sw_r;
  assign ifb.load = load_r;
  assign ifb.load_val = load_val_r;

  num_entry #(.DIGITS(DIGITS), .INIT(INIT), .DEB_CYCLES(DEB), .SAT_MODE(0),
              .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER))
    u_wrap (.clk(clk), .rst(rst), .bus(ifa));

  num_entry #(.DIGITS(DIGITS), .INIT(INIT), .DEB_CYCLES(DEB), .SAT_MODE(1),
              .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER))
    u_sat (.clk(clk), .rst(rst), .bus(ifb));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  // Synced input = raw sample taken two edges earlier (zeros after reset).
  logic [DIGITS-1:0] bq[$];
  logic [DIGITS-1:0] swq[$];
  logic [DIGITS-1:0] m_deb;
  int                run [DIGITS];   // consecutive edges synced != deb
  int                age [DIGITS];   // edges held since the press step
  logic [15:0]       m_num [2];      // [0]=wrap, [1]=saturate
  logic [3:0]        m_step [2];
  logic [DIGITS-1:0] sb, ss, mfire;
  logic              nd;

  function automatic logic [3:0] mdigit(input logic [3:0] d, input logic dn, input bit sat);
    int v;
    v = dn ? int'(d) - 1 : int'(d) + 1;
    if (sat) v = (v < 0) ? 0 : ((v > 15) ? 15 : v);
    else     v = (v + 16) % 16;
    return 4'(v);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      bq = '{4'b0, 4'b0};
      swq = '{4'b0, 4'b0};
      m_deb = '0;
      for (int i = 0; i < DIGITS; i++) begin
        run[i] = 0;
        age[i] = 0;
      end
      for (int s = 0; s < 2; s++) begin
        m_num[s] = INIT;
        m_step[s] = '0;
      end
    end else begin
      sb = bq.pop_front();
      ss = swq.pop_front();
      bq.push_back(btn_r);
      swq.push_back(sw_r);
      mfire = '0;
      for (int i = 0; i < DIGITS; i++) begin
        nd = m_deb[i];
        if (sb[i] != m_deb[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            nd = sb[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
        if (nd && !m_deb[i]) begin
          mfire[i] = 1'b1;
          age[i] = 0;
        end else if (nd && m_deb[i]) begin
          age[i]++;
`ifdef NUM_ENTRY_AUTOREPEAT_EN
          if (age[i] == RDLY || (age[i] > RDLY && (age[i] - RDLY) % RPER == 0))
            mfire[i] = 1'b1;
`endif
        end else begin
          age[i] = 0;
        end
        m_deb[i] = nd;
      end
      for (int s = 0; s < 2; s++) begin
        if (load_r) begin
          m_num[s] = load_val_r;
          m_step[s] = '0;
        end else begin
          for (int i = 0; i < DIGITS; i++)
            if (mfire[i]) m_num[s][4*i +: 4] = mdigit(m_num[s][4*i +: 4], ss[i], s == 1);
          m_step[s] = mfire;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_num_wrap", 32'(ifa.num), 32'(m_num[0]));
      check("model_step_wrap", 32'(ifa.step), 32'(m_step[0]));
      check("model_num_sat", 32'(ifb.num), 32'(m_num[1]));
      check("model_step_sat", 32'(ifb.step), 32'(m_step[1]));
    end
  end

  // ---------------- stimulus ----------------
  int rate;

  initial begin
    tick(3);
    chk_en = 1'b1;
    check("rst_num", 32'(ifa.num), 32'h0000_ABCD);
    check("rst_step", 32'(ifa.step), 32'h0);
    check("rst_num_sat", 32'(ifb.num), 32'h0000_ABCD);
    rst = 1'b0;
    tick(2);

    // single press, held 20 cycles
    btn_r[0] = 1'b1;
    sw_r = '0;
    tick(5);
    check("press_pre", 32'(ifa.num), 32'h0000_ABCD);
    tick(1);
    check("press_num", 32'(ifa.num), 32'h0000_ABCE);
    check("press_step", 32'(ifa.step), 32'b0001);
    tick(1);
    check("press_step_once", 32'(ifa.step), 32'h0);
    tick(13);
    btn_r[0] = 1'b0;
    tick(10);
    check("press_release", 32'(ifa.num), 32'h0000_ABCE);

    // 3-cycle glitches are rejected
    repeat (5) begin
      btn_r[1] = 1'b1;
      tick(3);
      btn_r[1] = 1'b0;
      tick(3);
    end
    tick(8);
    check("glitch_num", 32'(ifa.num), 32'h0000_ABCE);
    check("glitch_step", 32'(ifa.step), 32'h0);

    // wrap vs saturate at 0xF
    load_r = 1'b1;
    load_val_r = 16'hF000;
    tick(1);
    load_r = 1'b0;
    check("load_num", 32'(ifa.num), 32'h0000_F000);
    btn_r[3] = 1'b1;
    sw_r[3] = 1'b0;
    tick(6);
    check("wrap_num", 32'(ifa.num), 32'h0000_0000);
    check("sat_num", 32'(ifb.num), 32'h0000_F000);
    check("sat_step", 32'(ifb.step), 32'b1000);
    tick(4);
    btn_r[3] = 1'b0;
    tick(8);

    // load coinciding with the debounce-complete edge
    btn_r[2] = 1'b1;
    tick(5);
    load_r = 1'b1;
    load_val_r = 16'h1234;
    tick(1);
    load_r = 1'b0;
    check("loadstep_num", 32'(ifa.num), 32'h0000_1234);
    check("loadstep_step", 32'(ifa.step), 32'h0);
    tick(5);
    btn_r[2] = 1'b0;
    tick(8);
    check("loadstep_after", 32'(ifa.num), 32'h0000_1234);

    // long hold: auto-repeat when enabled, single step otherwise
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    btn_r[0] = 1'b1;
    sw_r[0] = 1'b0;
    tick(80);
    btn_r[0] = 1'b0;
    tick(15);
`ifdef NUM_ENTRY_AUTOREPEAT_EN
    check("hold80_num", 32'(ifa.num), 32'h0000_ABC1);
`else
    check("hold80_num", 32'(ifa.num), 32'h0000_ABCE);
`endif

    // button held through reset release: exactly one step, DEB+2 edges later
    btn_r[1] = 1'b1;
    sw_r[1] = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
    check("rsthold_pre", 32'(ifa.num), 32'h0000_ABCD);
    tick(1);
    check("rsthold_num", 32'(ifa.num), 32'h0000_ABDD);
    check("rsthold_step", 32'(ifa.step), 32'b0010);
    tick(20);
    btn_r[1] = 1'b0;
    tick(10);
    check("rsthold_once", 32'(ifa.num), 32'h0000_ABDD);

    // random activity; rate alternates between bouncy and long-hold regimes
    for (int blk = 0; blk < 8; blk++) begin
      rate = (blk % 2 == 0) ? 7 : 120;
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < DIGITS; i++) begin
          if ($urandom_range(0, rate) == 0) btn_r[i] = ~btn_r[i];
          if ($urandom_range(0, 15) == 0) sw_r[i] = ~sw_r[i];
        end
        load_r = ($urandom_range(0, 39) == 0);
        load_val_r = 16'($urandom);
        rst = ($urandom_range(0, 499) == 0);
        tick(1);
      end
    end
    rst = 1'b0;
    load_r = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
